// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - RV32M funct3 encodings, FSM states and operand signedness helpers
package muldiv_pkg;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
               (op == MULDIV_DIV)  || (op == MULDIV_REM);
    endfunction

    // rs2 is treated as two's complement for MULH, DIV and REM
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative shift-add multiplier / restoring divider for RV32M
module muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      op_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_t   state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            special_q;
    // hi_q: product high half (mul) or partial remainder (div)
    // lo_q: multiplier shifting out / product low half (mul), dividend shifting into quotient (div)
    logic [XLEN:0]   hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opnd_q;

    logic            a_neg, b_neg, res_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    // Accept-side decode: magnitudes, result sign and special-case detection
    always_comb begin
        a_neg    = op_a_signed(op_i) & a_i[XLEN-1];
        b_neg    = op_b_signed(op_i) & b_i[XLEN-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        res_neg  = (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = op_i[2] && (b_i == '0);
        div_ovf  = op_i[2] && !op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
        if (div_zero)
            special_res = op_i[1] ? a_i : '1;
        else
            special_res = op_i[1] ? '0 : a_i;
    end

    logic            is_mul;
    logic            fits;
    logic [XLEN:0]   div_shift, add_a, add_b, add_sum, hi_n;
    logic [XLEN-1:0] lo_n;

    // One iteration; the XLEN+1-bit adder adds the multiplicand or subtracts the divisor
    always_comb begin
        is_mul    = !op_q[2];
        div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        add_a     = is_mul ? hi_q : div_shift;
        if (is_mul)
            add_b = lo_q[0] ? {1'b0, opnd_q} : '0;
        else
            add_b = ~{1'b0, opnd_q};
        add_sum   = add_a + add_b + {{XLEN{1'b0}}, !is_mul};
        fits      = !add_sum[XLEN];
        if (is_mul) begin
            hi_n = {1'b0, add_sum[XLEN:1]};
            lo_n = {add_sum[0], lo_q[XLEN-1:1]};
        end else begin
            hi_n = fits ? add_sum : div_shift;
            lo_n = {lo_q[XLEN-2:0], fits};
        end
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    // Final sign fix-up and result selection
    always_comb begin
        prod   = {hi_q[XLEN-1:0], lo_q};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo_q : lo_q;
        rem_s  = neg_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
        if (special_q)
            final_res = lo_q;
        else if (is_mul)
            final_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else
            final_res = op_q[1] ? rem_s : quo_s;
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            ready_o   <= 1'b1;
            valid_o   <= 1'b0;
            result_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_o <= 1'b0;
                    if (ready_o && valid_i) begin
                        ready_o   <= 1'b0;
                        op_q      <= op_i;
                        neg_q     <= res_neg;
                        special_q <= div_zero | div_ovf;
                        hi_q      <= '0;
                        lo_q      <= (div_zero | div_ovf) ? special_res : a_mag;
                        opnd_q    <= b_mag;
                        cnt       <= CW'(XLEN - 1);
                        state     <= (div_zero | div_ovf) ? ST_DONE : ST_CALC;
                    end else if (!ready_o) begin
                        // ready rises one cycle after the result strobe
                        ready_o <= 1'b1;
                    end
                end
                ST_CALC: begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                    if (cnt == '0)
                        state <= ST_DONE;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_DONE: begin
                    result_o <= final_res;
                    valid_o  <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
